// File: rtl/hazard_fwd_unit.sv
// Purpose: in-flight destination scoreboard, operand bypass select, load-use/multi-cycle hold, jump flush, stall count.
// Latency: forwarding, hold_o and flush_o onset are combinational; scoreboard and counters update on the next clk edge.
// Backpressure: hold_o freezes the front end and converts the ID slot into a bubble; flush_o squashes the issued instruction.
module hazard_fwd_unit #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int NFWD      = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid_i,
    input  logic                 iss_we_i,
    input  logic [AW-1:0]        iss_waddr_i,
    input  logic                 iss_load_i,
    input  logic [NRD*AW-1:0]    id_raddr_i,
    input  logic [NRD*XLEN-1:0]  reg_rdata_i,
    input  logic [NFWD*XLEN-1:0] stage_wdata_i,
    input  logic                 alu_busy_i,
    input  logic                 jump_flag_i,
    output logic [NRD*XLEN-1:0]  fwd_rdata_o,
    output logic                 hold_o,
    output logic                 flush_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int FW = ($clog2(FLUSH_CYC) < 2) ? 2 : $clog2(FLUSH_CYC);

    logic [NFWD-1:0] v_q, v_d, we_q, we_d, load_q, load_d;
    logic [AW-1:0]   addr_q [NFWD];
    logic [AW-1:0]   addr_d [NFWD];
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            hazard_any;
    logic            jump_take;
    logic            flush_raw;

    assign jump_take = jump_flag_i & ~alu_busy_i;
    assign flush_raw = jump_take | (fcnt_q != '0);

    // Outputs are gated by reset so the block is inert while rst_n is low.
    assign flush_o     = rst_n & flush_raw;
    assign hold_o      = rst_n & ~flush_raw & (alu_busy_i | hazard_any);
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        fwd_rdata_o = reg_rdata_i;
        hazard_any  = 1'b0;
        for (int r = 0; r < NRD; r++) begin
            logic [AW-1:0] ra;
            logic          win0;
            ra   = id_raddr_i[r*AW +: AW];
            win0 = 1'b0;
            // Walk oldest to youngest so the youngest (lowest k) match wins.
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (v_q[k] && we_q[k] && (addr_q[k] == ra) && (addr_q[k] != '0)) begin
                    fwd_rdata_o[r*XLEN +: XLEN] = stage_wdata_i[k*XLEN +: XLEN];
                    win0 = (k == 0);
                end
            end
            if (ra == '0) begin
                fwd_rdata_o[r*XLEN +: XLEN] = '0;
                win0 = 1'b0;
            end
            if (iss_valid_i && win0 && (load_q[0] || alu_busy_i)) begin
                hazard_any = 1'b1;
            end
        end
    end

    always_comb begin
        v_d    = v_q;
        we_d   = we_q;
        load_d = load_q;
        addr_d = addr_q;
        for (int k = 2; k < NFWD; k++) begin
            v_d[k]    = v_q[k-1];
            we_d[k]   = we_q[k-1];
            load_d[k] = load_q[k-1];
            addr_d[k] = addr_q[k-1];
        end
        if (alu_busy_i) begin
            // EX is occupied: entry 0 stays put and a bubble drains into MEM.
            v_d[1]    = 1'b0;
            we_d[1]   = 1'b0;
            load_d[1] = 1'b0;
        end else begin
            v_d[1]    = v_q[0];
            we_d[1]   = we_q[0];
            load_d[1] = load_q[0];
            addr_d[1] = addr_q[0];
            v_d[0]    = iss_valid_i & ~hold_o & ~flush_o;
            we_d[0]   = iss_we_i;
            load_d[0] = iss_load_i;
            addr_d[0] = iss_waddr_i;
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (jump_take) begin
            fcnt_d = FW'(FLUSH_CYC - 1);
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (hold_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            we_q        <= '0;
            load_q      <= '0;
            for (int k = 0; k < NFWD; k++) begin
                addr_q[k] <= '0;
            end
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            we_q        <= we_d;
            load_q      <= load_d;
            addr_q      <= addr_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
